// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size and FSM
// encodings, the pre-split byte-enable mask and the load merge/extend step.
package lsu_pkg;

    // Distance between the two word addresses of a split access
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    // Encoding 2'b11 is not listed and behaves as a word access
    typedef enum logic [1:0] {
        MT_WORD = 2'b00,
        MT_BYTE = 2'b01,
        MT_HALF = 2'b10
    } mem_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    // Byte-enable mask across two consecutive words; the low nibble belongs to
    // the first word and the high nibble to the second word of a split access
    function automatic logic [7:0] be_mask8(input logic [1:0] mem_type,
                                            input logic [1:0] offset);
        logic [7:0] base;
        case (mem_type)
            MT_BYTE: base = 8'h01;
            MT_HALF: base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << offset;
    endfunction

    // Merge the two fetched words, move the addressed byte to lane 0 and
    // extend to 32 bits; zero_ext=1 selects zero extension
    function automatic logic [31:0] load_extend(input logic [31:0] high_word,
                                                input logic [31:0] low_word,
                                                input logic [1:0]  mem_type,
                                                input logic [1:0]  offset,
                                                input logic        zero_ext);
        logic [31:0] aligned;
        logic [31:0] result;
        aligned = 32'({high_word, low_word} >> {offset, 3'b000});
        case (mem_type)
            MT_BYTE: result = zero_ext ? {24'h0, aligned[7:0]}
                                       : {{24{aligned[7]}}, aligned[7:0]};
            MT_HALF: result = zero_ext ? {16'h0, aligned[15:0]}
                                       : {{16{aligned[15]}}, aligned[15:0]};
            default: result = aligned;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and shifted store data for both
// words of an access, plus the flag saying the access spans two words.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  mem_type,
    input  logic [1:0]  offset,
    input  logic [31:0] write_data,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic        split
);

    logic [7:0]  mask;
    logic [63:0] shifted;
    logic        is_word;

    assign mask     = be_mask8(mem_type, offset);
    assign be_lo    = mask[3:0];
    assign be_hi    = mask[7:4];

    // Bytes shifted past lane 3 land in the second word's low lanes
    assign shifted  = {32'h0, write_data} << {offset, 3'b000};
    assign wdata_lo = shifted[31:0];
    assign wdata_hi = shifted[63:32];

    assign is_word  = (mem_type == MT_WORD) || (mem_type == 2'b11);
    assign split    = ((mem_type == MT_HALF) && (offset == 2'd3)) ||
                      (is_word && (offset != 2'd0));

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues one or two
// word-aligned bus transactions and returns the extended load result.
// Optional build macro LSU_MISALIGN_TRAP_EN: accesses that would need two
// words complete immediately with MisalignErr_o instead of being split.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReqValid_i,
    output logic                  ReqReady_o,
    input  logic [DATA_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    output logic                  RespValid_o,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  MisalignErr_o,
    output logic                  BusReq_o,
    input  logic                  BusAck_i,
    output logic [DATA_WIDTH-1:0] BusAddr_o,
    output logic                  BusWe_o,
    output logic [3:0]            BusBe_o,
    output logic [DATA_WIDTH-1:0] BusWData_o,
    input  logic [DATA_WIDTH-1:0] BusRData_i
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_t state, next_state;

    logic [3:0]            be_lo, be_hi;
    logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi;
    logic                  split_in;
    logic                  take_trap;

    logic [1:0]            type_q;
    logic [1:0]            offset_q;
    logic                  zext_q;
    logic                  write_q;
    logic                  split_q;
    logic [3:0]            be_hi_q;
    logic [DATA_WIDTH-1:0] wdata_hi_q;
    logic [DATA_WIDTH-1:0] low_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    logic                  bus_req;
    logic [DATA_WIDTH-1:0] bus_addr;
    logic                  bus_we;
    logic [3:0]            bus_be;
    logic [DATA_WIDTH-1:0] bus_wdata;

    lsu_lane_align u_lane_align (
        .mem_type   (MemType_i),
        .offset     (Addr_i[1:0]),
        .write_data (WriteData_i),
        .be_lo      (be_lo),
        .be_hi      (be_hi),
        .wdata_lo   (wdata_lo),
        .wdata_hi   (wdata_hi),
        .split      (split_in)
    );

    assign take_trap = TRAP_EN && split_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; a trapped request skips the bus entirely
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ReqValid_i) begin
                    next_state = take_trap ? ST_DONE : ST_ACC0;
                end
            end
            ST_ACC0: begin
                if (BusAck_i) begin
                    next_state = split_q ? ST_ACC1 : ST_DONE;
                end
            end
            ST_ACC1: begin
                if (BusAck_i) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Request capture, registered bus outputs and load result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q      <= 2'b00;
            offset_q    <= 2'b00;
            zext_q      <= 1'b0;
            write_q     <= 1'b0;
            split_q     <= 1'b0;
            be_hi_q     <= 4'h0;
            wdata_hi_q  <= '0;
            low_q       <= '0;
            read_data_q <= '0;
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            bus_we      <= 1'b0;
            bus_be      <= 4'h0;
            bus_wdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ReqValid_i) begin
                        type_q     <= MemType_i;
                        offset_q   <= Addr_i[1:0];
                        zext_q     <= MemSign_i;
                        write_q    <= MemWrite_i;
                        split_q    <= split_in;
                        be_hi_q    <= be_hi;
                        wdata_hi_q <= wdata_hi;
                        if (!take_trap) begin
                            bus_req   <= 1'b1;
                            bus_addr  <= {Addr_i[DATA_WIDTH-1:2], 2'b00};
                            bus_we    <= MemWrite_i;
                            bus_be    <= be_lo;
                            bus_wdata <= wdata_lo;
                        end
                    end
                end
                ST_ACC0: begin
                    if (BusAck_i) begin
                        low_q <= BusRData_i;
                        if (split_q) begin
                            bus_addr  <= bus_addr + WORD_STRIDE;
                            bus_be    <= be_hi_q;
                            bus_wdata <= wdata_hi_q;
                        end else begin
                            bus_req <= 1'b0;
                            bus_we  <= 1'b0;
                            bus_be  <= 4'h0;
                            if (!write_q) begin
                                read_data_q <= load_extend('0, BusRData_i,
                                                           type_q, offset_q, zext_q);
                            end
                        end
                    end
                end
                ST_ACC1: begin
                    if (BusAck_i) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= 4'h0;
                        if (!write_q) begin
                            read_data_q <= load_extend(BusRData_i, low_q,
                                                       type_q, offset_q, zext_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    // Error flag accompanies the single DONE cycle of a trapped request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == ST_IDLE) && ReqValid_i && take_trap;
        end
    end

    assign MisalignErr_o = misalign_q;
`else
    assign MisalignErr_o = 1'b0;
`endif

    assign ReqReady_o  = (state == ST_IDLE);
    assign RespValid_o = (state == ST_DONE);
    assign ReadData_o  = read_data_q;
    assign BusReq_o    = bus_req;
    assign BusAddr_o   = bus_addr;
    assign BusWe_o     = bus_we;
    assign BusBe_o     = bus_be;
    assign BusWData_o  = bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases followed by random loads and
// stores against a byte-addressed reference memory and a bus memory slave.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ReqValid_i;
    logic        ReqReady_o;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        MemWrite_i;
    logic [1:0]  MemType_i;
    logic        MemSign_i;
    logic        RespValid_o;
    logic [31:0] ReadData_o;
    logic        MisalignErr_o;
    logic        BusReq_o;
    logic        BusAck_i;
    logic [31:0] BusAddr_o;
    logic        BusWe_o;
    logic [3:0]  BusBe_o;
    logic [31:0] BusWData_o;
    logic [31:0] BusRData_i;

    int total;
    int bad;

    logic [31:0] bus_mem [logic [29:0]];
    logic [7:0]  shadow  [logic [31:0]];

    logic [31:0] txn_addr[$];
    logic [3:0]  txn_be[$];
    logic        txn_we[$];
    logic [31:0] txn_wdata[$];
    int          txn_delay[$];

    int          fixed_delay;
    int          slave_wait;
    int          cur_delay;
    int          lat;
    logic [31:0] last_read;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ReqValid_i    (ReqValid_i),
        .ReqReady_o    (ReqReady_o),
        .Addr_i        (Addr_i),
        .WriteData_i   (WriteData_i),
        .MemWrite_i    (MemWrite_i),
        .MemType_i     (MemType_i),
        .MemSign_i     (MemSign_i),
        .RespValid_o   (RespValid_o),
        .ReadData_o    (ReadData_o),
        .MisalignErr_o (MisalignErr_o),
        .BusReq_o      (BusReq_o),
        .BusAck_i      (BusAck_i),
        .BusAddr_o     (BusAddr_o),
        .BusWe_o       (BusWe_o),
        .BusBe_o       (BusBe_o),
        .BusWData_o    (BusWData_o),
        .BusRData_i    (BusRData_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int n = 0; n < 4; n++) w[8*n +: 8] = ref_byte({a[31:2], 2'b00} + 32'(n));
        return w;
    endfunction

    function automatic logic [31:0] slave_read(input logic [29:0] idx);
        logic [31:0] w;
        if (bus_mem.exists(idx)) return bus_mem[idx];
        for (int n = 0; n < 4; n++) w[8*n +: 8] = init_byte({idx, 2'b00} + 32'(n));
        return w;
    endfunction

    task automatic preload(input logic [29:0] idx, input logic [31:0] value);
        bus_mem[idx] = value;
        for (int n = 0; n < 4; n++) shadow[{idx, 2'b00} + 32'(n)] = value[8*n +: 8];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Bus memory slave: acks after a chosen delay, logs every transaction
    initial begin : bus_slave
        logic [31:0] w;
        BusAck_i   = 1'b0;
        BusRData_i = 32'h0;
        slave_wait = -1;
        cur_delay  = 0;
        forever begin
            @(negedge clk);
            BusAck_i = 1'b0;
            if (rst_n && BusReq_o) begin
                if (slave_wait < 0) begin
                    slave_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
                    cur_delay  = slave_wait;
                end
                if (slave_wait == 0) begin
                    BusAck_i   = 1'b1;
                    BusRData_i = slave_read(BusAddr_o[31:2]);
                    txn_addr.push_back(BusAddr_o);
                    txn_be.push_back(BusBe_o);
                    txn_we.push_back(BusWe_o);
                    txn_wdata.push_back(BusWData_o);
                    txn_delay.push_back(cur_delay);
                    if (BusWe_o) begin
                        w = slave_read(BusAddr_o[31:2]);
                        for (int n = 0; n < 4; n++)
                            if (BusBe_o[n]) w[8*n +: 8] = BusWData_o[8*n +: 8];
                        bus_mem[BusAddr_o[31:2]] = w;
                    end
                    slave_wait = -1;
                end else begin
                    slave_wait--;
                end
            end else begin
                slave_wait = -1;
            end
        end
    end

    // Issue one request, wait for its response and check it against the model
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic wr, input logic [1:0] mt, input logic sgn);
        int          size;
        bit          split_exp;
        bit          trap_exp;
        int          exp_txns;
        int          dsum;
        logic [31:0] first;
        logic [31:0] second;
        logic [31:0] b;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] raw;
        size      = (mt == 2'b01) ? 1 : (mt == 2'b10) ? 2 : 4;
        split_exp = (int'(addr[1:0]) + size) > 4;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_exp  = split_exp;
`else
        trap_exp  = 1'b0;
`endif
        first  = {addr[31:2], 2'b00};
        second = first + 32'd4;
        be0 = 4'h0;
        be1 = 4'h0;
        for (int i = 0; i < size; i++) begin
            b = addr + 32'(i);
            if (b[31:2] == first[31:2]) be0[b[1:0]] = 1'b1;
            else                        be1[b[1:0]] = 1'b1;
        end
        exp_txns = trap_exp ? 0 : (split_exp ? 2 : 1);

        @(negedge clk);
        txn_addr.delete(); txn_be.delete(); txn_we.delete();
        txn_wdata.delete(); txn_delay.delete();
        checkOutput("ready_idle", 32'(ReqReady_o), 32'd1);
        ReqValid_i  = 1'b1;
        Addr_i      = addr;
        WriteData_i = wdata;
        MemWrite_i  = wr;
        MemType_i   = mt;
        MemSign_i   = sgn;
        @(posedge clk);
        @(negedge clk);
        ReqValid_i = 1'b0;
        lat = 1;
        while (!RespValid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!RespValid_o) begin
            checkOutput("resp_timeout", 32'(RespValid_o), 32'd1);
            return;
        end

        dsum = 0;
        foreach (txn_delay[k]) dsum += txn_delay[k];
        checkOutput("latency", 32'(lat),
                    trap_exp ? 32'd1 : 32'(2 + dsum + (split_exp ? 1 : 0)));
        checkOutput("txn_count", 32'(txn_addr.size()), 32'(exp_txns));
        checkOutput("misalign", 32'(MisalignErr_o), 32'(trap_exp));
        checkOutput("ready_in_done", 32'(ReqReady_o), 32'd0);
        if (txn_addr.size() >= 1) begin
            checkOutput("addr0", txn_addr[0], first);
            checkOutput("be0", 32'(txn_be[0]), 32'(be0));
            checkOutput("we0", 32'(txn_we[0]), 32'(wr));
        end
        if (txn_addr.size() >= 2) begin
            checkOutput("addr1", txn_addr[1], second);
            checkOutput("be1", 32'(txn_be[1]), 32'(be1));
            checkOutput("we1", 32'(txn_we[1]), 32'(wr));
        end

        if (!trap_exp) begin
            if (wr) begin
                for (int i = 0; i < size; i++) shadow[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                raw = 32'h0;
                for (int i = 0; i < size; i++) raw |= 32'(ref_byte(addr + 32'(i))) << (8*i);
                if (size < 4 && !sgn && raw[8*size-1]) raw = raw - (32'd1 << (8*size));
                last_read = raw;
            end
        end
        checkOutput("read_data", ReadData_o, last_read);
        if (wr) begin
            checkOutput("mem_word0", slave_read(first[31:2]), ref_word(first));
            checkOutput("mem_word1", slave_read(second[31:2]), ref_word(second));
        end

        @(negedge clk);
        checkOutput("resp_pulse", 32'(RespValid_o), 32'd0);
    endtask

    initial begin : main
        int seen;
        total = 0;
        bad = 0;
        fixed_delay = 0;
        last_read = 32'h0;
        ReqValid_i = 1'b0;
        Addr_i = 32'h0;
        WriteData_i = 32'h0;
        MemWrite_i = 1'b0;
        MemType_i = 2'b00;
        MemSign_i = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_ready", 32'(ReqReady_o), 32'd1);
        checkOutput("rst_resp", 32'(RespValid_o), 32'd0);
        checkOutput("rst_rdata", ReadData_o, 32'h0);
        checkOutput("rst_misalign", 32'(MisalignErr_o), 32'd0);
        checkOutput("rst_busreq", 32'(BusReq_o), 32'd0);
        checkOutput("rst_buswe", 32'(BusWe_o), 32'd0);
        checkOutput("rst_busbe", 32'(BusBe_o), 32'd0);
        checkOutput("rst_busaddr", BusAddr_o, 32'h0);
        checkOutput("rst_buswdata", BusWData_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // lb from the top byte of a word, sign-extended
        preload(30'h40, 32'h80AA_BBCC);
        applyStimulus(32'h0000_0103, 32'h0, 1'b0, 2'b01, 1'b0);
        checkOutput("lb_latency", 32'(lat), 32'd2);
        checkOutput("lb_data", ReadData_o, 32'hFFFF_FF80);
        if (txn_addr.size() > 0) begin
            checkOutput("lb_addr", txn_addr[0], 32'h0000_0100);
            checkOutput("lb_be", 32'(txn_be[0]), 32'h8);
        end

        // lhu from the upper half, zero-extended
        preload(30'h80, 32'h8001_0000);
        applyStimulus(32'h0000_0202, 32'h0, 1'b0, 2'b10, 1'b1);
        checkOutput("lhu_data", ReadData_o, 32'h0000_8001);
        if (txn_be.size() > 0) checkOutput("lhu_be", 32'(txn_be[0]), 32'hC);

        // Unaligned sw and lw wrapping past the top of the address space
        applyStimulus(32'h0000_0305, 32'h1122_3344, 1'b1, 2'b00, 1'b0);
        preload(30'h3FFF_FFFF, 32'hAAAA_0000);
        preload(30'h0, 32'h0000_BBBB);
        applyStimulus(32'hFFFF_FFFE, 32'h0, 1'b0, 2'b00, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
        checkOutput("lw_wrap_data", ReadData_o, 32'hBBBB_AAAA);
        if (txn_addr.size() == 2) checkOutput("lw_wrap_addr1", txn_addr[1], 32'h0);
`endif

        // sh straddling a word boundary (trapped when the trap option is built)
        applyStimulus(32'h0000_0003, 32'h0000_BEEF, 1'b1, 2'b10, 1'b0);

        // Reset pulse while a slow transaction is pending
        fixed_delay = 5;
        @(negedge clk);
        ReqValid_i = 1'b1;
        Addr_i     = 32'h0000_0040;
        MemWrite_i = 1'b0;
        MemType_i  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        ReqValid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busreq", 32'(BusReq_o), 32'd0);
        checkOutput("abort_ready", 32'(ReqReady_o), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (RespValid_o) seen++;
        end
        checkOutput("abort_no_resp", 32'(seen), 32'd0);
        checkOutput("abort_rdata", ReadData_o, 32'h0);
        last_read = 32'h0;
        fixed_delay = 0;
        preload(30'h10, 32'h1234_5678);
        applyStimulus(32'h0000_0040, 32'h0, 1'b0, 2'b00, 1'b0);
        checkOutput("post_reset_data", ReadData_o, 32'h1234_5678);

        // Random traffic over a small window and across the address wrap
        fixed_delay = -1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 15))
                                           : 32'h0000_1000 + 32'($urandom_range(0, 31));
            applyStimulus(a, $urandom, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
